raster: RTL and testbench

RASTER -- requirements
Module: raster

---
 rtl/raster_pkg.sv | 34 +++
 rtl/edge_acc.sv | 45 ++++
 rtl/raster.sv | 100 ++++++++++
 tb/tb_raster.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// +--------------------------------------------------------------------+
// | raster_pkg : shared timing constants and edge-flag types for raster |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package raster_pkg;

  localparam int COORD_W = 20;
  localparam int PIX_W   = 6;
  localparam int CNT_W   = 19;
  localparam int POS_W   = 10;

  localparam logic [POS_W-1:0] H_ACTIVE = 10'd640;
  localparam logic [POS_W-1:0] H_LAST   = 10'd799;
  localparam logic [POS_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [POS_W-1:0] V_LAST   = 10'd524;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic ge0;
    logic le0;
  } edge_flags_t;

  // Covered when all three edges agree in sign, which accepts either winding.
  function automatic logic is_inside(input edge_flags_t f0, input edge_flags_t f1,
                                     input edge_flags_t f2);
    return (f0.ge0 && f1.ge0 && f2.ge0) || (f0.le0 && f1.le0 && f2.le0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_acc.sv
// +--------------------------------------------------------------------+
// | edge_acc : one edge-function accumulator with its per-pixel x-step  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module edge_acc
  import raster_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step_load,
  input  logic signed [COORD_W-1:0] step_in,
  input  logic                      acc_load,
  input  logic signed [COORD_W-1:0] acc_init,
  input  logic                      acc_step,
  output edge_flags_t               flags
);

  coord_t r_step;
  coord_t r_acc;

  // A line reload wins over stepping; the step register is independent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step <= '0;
      r_acc  <= '0;
    end else begin
      if (step_load) begin
        r_step <= step_in;
      end
      if (acc_load) begin
        r_acc <= acc_init;
      end else if (acc_step) begin
        r_acc <= r_acc + r_step;
      end
    end
  end

  assign flags.ge0 = ~r_acc[COORD_W-1];
  assign flags.le0 = r_acc[COORD_W-1] | (r_acc == '0);

endmodule

`default_nettype wire

// File: rtl/raster.sv
// +--------------------------------------------------------------------+
// | raster : scanline triangle coverage test with per-frame hit count   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module raster
  import raster_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [POS_W-1:0]          x,
  input  logic [POS_W-1:0]          y,
  input  logic signed [COORD_W-1:0] x_screen_v0,
  input  logic signed [COORD_W-1:0] x_screen_v1,
  input  logic signed [COORD_W-1:0] x_screen_v2,
  input  logic signed [COORD_W-1:0] y_screen_v0,
  input  logic signed [COORD_W-1:0] y_screen_v1,
  input  logic signed [COORD_W-1:0] y_screen_v2,
  input  logic signed [COORD_W-1:0] e0_init_t1,
  input  logic signed [COORD_W-1:0] e1_init_t1,
  input  logic signed [COORD_W-1:0] e2_init_t1,
  input  logic [1:0]                tri_color,
  output logic                      hit,
  output logic [PIX_W-1:0]          pixel,
  output logic [CNT_W-1:0]          frame_hits
);

  logic              w_active;
  logic              w_frame_latch;
  logic              w_reload;
  logic              w_frame_end;
  logic              w_inside;
  logic              w_hit_now;
  coord_t            w_step  [3];
  coord_t            w_init  [3];
  edge_flags_t       w_flags [3];

  logic              r_hit;
  logic [PIX_W-1:0]  r_pixel;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_frame_hits;

  // Screen-space x of the vertices is folded into the edge inits upstream.
  logic w_unused;
  assign w_unused = ^{x_screen_v0, x_screen_v1, x_screen_v2};

  assign w_active      = (x < H_ACTIVE) && (y < V_ACTIVE);
  assign w_frame_latch = (x == H_LAST) && (y == V_LAST);
  assign w_reload      = (x == H_LAST) && ((y < (V_ACTIVE - 10'd1)) || (y == V_LAST));
  assign w_frame_end   = (x == '0) && (y == V_ACTIVE);

  assign w_step[0] = y_screen_v1 - y_screen_v0;
  assign w_step[1] = y_screen_v2 - y_screen_v1;
  assign w_step[2] = y_screen_v0 - y_screen_v2;
  assign w_init[0] = e0_init_t1;
  assign w_init[1] = e1_init_t1;
  assign w_init[2] = e2_init_t1;

  for (genvar i = 0; i < 3; i++) begin : g_edge
    edge_acc u_edge_acc (
      .clk       (clk),
      .reset     (reset),
      .step_load (w_frame_latch),
      .step_in   (w_step[i]),
      .acc_load  (w_reload),
      .acc_init  (w_init[i]),
      .acc_step  (w_active),
      .flags     (w_flags[i])
    );
  end

  assign w_inside  = is_inside(w_flags[0], w_flags[1], w_flags[2]);
  assign w_hit_now = w_active && w_inside;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit        <= 1'b0;
      r_pixel      <= '0;
      r_count      <= '0;
      r_frame_hits <= '0;
    end else begin
      r_hit   <= w_hit_now;
      r_pixel <= w_hit_now ? {3{tri_color}} : '0;
      if (w_frame_end) begin
        r_frame_hits <= r_count;
        r_count      <= '0;
      end else if (w_hit_now) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign hit        = r_hit;
  assign pixel      = r_pixel;
  assign frame_hits = r_frame_hits;

endmodule

`default_nettype wire

// File: tb/tb_raster.sv
// +--------------------------------------------------------------------+
// | tb_raster : self-checking bench for raster (abbreviated frames)     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_raster;
  import raster_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        x = 10'd700;
  logic [9:0]        y = 10'd490;
  coord_t            x_screen_v0 = '0, x_screen_v1 = '0, x_screen_v2 = '0;
  coord_t            y_screen_v0 = '0, y_screen_v1 = '0, y_screen_v2 = '0;
  coord_t            e0_init_t1 = '0, e1_init_t1 = '0, e2_init_t1 = '0;
  logic [1:0]        tri_color = 2'b00;
  logic              hit;
  logic [5:0]        pixel;
  logic [18:0]       frame_hits;

  always #5 clk = ~clk;

  raster dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .x_screen_v0 (x_screen_v0),
    .x_screen_v1 (x_screen_v1),
    .x_screen_v2 (x_screen_v2),
    .y_screen_v0 (y_screen_v0),
    .y_screen_v1 (y_screen_v1),
    .y_screen_v2 (y_screen_v2),
    .e0_init_t1  (e0_init_t1),
    .e1_init_t1  (e1_init_t1),
    .e2_init_t1  (e2_init_t1),
    .tri_color   (tri_color),
    .hit         (hit),
    .pixel       (pixel),
    .frame_hits  (frame_hits)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
    logic [5:0] pix;
  } exp_t;

  typedef struct {
    int         v0y;
    int         v1y;
    int         v2y;
    int         init;
    logic [1:0] color;
    int         xmax;
    int         last;
    int         fh;
  } scen_t;

  exp_t  sb_q[$];
  scen_t tbl[5];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync_check();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("hit(%0d,%0d)", e.x, e.y), 32'(hit), 32'(e.hit));
      check($sformatf("pixel(%0d,%0d)", e.x, e.y), 32'(pixel), 32'(e.pix));
    end
  endtask

  task automatic drive(input int xx, input int yy, input logic h);
    exp_t e;
    x     = 10'(xx);
    y     = 10'(yy);
    e.x   = x;
    e.y   = y;
    e.hit = h;
    e.pix = h ? {3{tri_color}} : 6'd0;
    sb_q.push_back(e);
  endtask

  task automatic step(input int xx, input int yy, input logic h);
    sync_check();
    drive(xx, yy, h);
  endtask

  // Scan x=0..xmax of a line (hits expected up to x=last), then blank and reload points.
  task automatic scan_line(input int yy, input int xmax, input int last);
    for (int i = 0; i <= xmax; i++) step(i, yy, i <= last);
    step(640, yy, 1'b0);
    step(799, yy, 1'b0);
  endtask

  task automatic end_frame(input int exp_fh);
    step(0, 480, 1'b0);
    sync_check();
    check("frame_hits", 32'(frame_hits), 32'(exp_fh));
    drive(700, 490, 1'b0);
  endtask

  task automatic set_verts(input int v0y, input int v1y, input int v2y, input int init);
    x_screen_v0 = '0; x_screen_v1 = '0; x_screen_v2 = '0;
    y_screen_v0 = 20'(v0y);
    y_screen_v1 = 20'(v1y);
    y_screen_v2 = 20'(v2y);
    e0_init_t1  = 20'(init);
    e1_init_t1  = 20'(init);
    e2_init_t1  = 20'(init);
  endtask

  initial begin
    // v0y v1y v2y init color xmax last frame_hits (5 lines scanned per frame)
    tbl[0] = '{0, 0, 0,    5, 2'b11, 15, 1023,  80};
    tbl[1] = '{1, 0, 1,  100, 2'b01, 103, 100, 505};
    tbl[2] = '{0, 1, 0, -100, 2'b10, 103, 100, 505};
    tbl[3] = '{1, 0, 1,   20, 2'b11, 25,   20, 105};
    tbl[4] = '{1, 0, 1,   -5, 2'b01, 8,     5,  30};

    #2 reset = 1'b0;
    #1;
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_pixel", 32'(pixel), 32'd0);
    check("reset_frame_hits", 32'(frame_hits), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int s = 0; s < 5; s++) begin
      tri_color = tbl[s].color;
      set_verts(tbl[s].v0y, tbl[s].v1y, tbl[s].v2y, tbl[s].init);
      step(799, 524, 1'b0);
      scan_line(0, tbl[s].xmax, tbl[s].last);
      scan_line(1, tbl[s].xmax, tbl[s].last);
      scan_line(2, tbl[s].xmax, tbl[s].last);
      step(799, 477, 1'b0);
      scan_line(478, tbl[s].xmax, tbl[s].last);
      scan_line(479, tbl[s].xmax, tbl[s].last);
      end_frame(tbl[s].fh);
    end

    // Mid-frame reset while a covered pixel is on the output.
    tri_color = 2'b01;
    set_verts(1, 0, 1, 100);
    step(799, 524, 1'b0);
    step(799, 99, 1'b0);
    for (int i = 0; i <= 50; i++) step(i, 100, 1'b1);
    sync_check();
    x = 10'd300;
    y = 10'd100;
    reset = 1'b0;
    #1;
    check("midreset_hit", 32'(hit), 32'd0);
    check("midreset_pixel", 32'(pixel), 32'd0);
    check("midreset_frame_hits", 32'(frame_hits), 32'd0);
    x = 10'd700;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(700, 100, 1'b0);
    step(799, 100, 1'b0);
    // Steps are zero until the next frame latch, so every pixel is covered.
    scan_line(101, 103, 1023);
    step(799, 478, 1'b0);
    scan_line(479, 103, 1023);
    end_frame(208);

    // Vertex change mid-frame only takes effect on the next frame.
    tri_color = 2'b11;
    set_verts(1, 0, 1, 100);
    step(799, 524, 1'b0);
    scan_line(0, 103, 100);
    step(799, 199, 1'b0);
    y_screen_v1 = 20'sd5;
    scan_line(200, 103, 100);
    scan_line(201, 103, 100);
    end_frame(303);
    step(799, 524, 1'b0);
    scan_line(0, 30, 25);
    scan_line(1, 30, 25);
    end_frame(52);

    // e0 init changed at x=640 of line 10 applies from line 11.
    tri_color = 2'b10;
    set_verts(1, 0, 1, 100);
    step(799, 524, 1'b0);
    step(799, 8, 1'b0);
    scan_line(9, 103, 100);
    for (int i = 0; i <= 103; i++) step(i, 10, i <= 100);
    step(640, 10, 1'b0);
    e0_init_t1 = 20'sd50;
    step(799, 10, 1'b0);
    scan_line(11, 103, 50);
    end_frame(253);

    sync_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
